rtc_set_ctrl: RTL and testbench

- Time-set controller that sequences the HH:MM:SS counter datapath.
- Replaces the free-form set switch with a mode/up/down button FSM. It freezes counting, edits a shadow copy of the time field by field with auto-repeat, then issues a one-cycle parallel load to the counters.
- Also drives per-digit blink masks for the seven-segment stage.
- Sits between the button debouncers and the time counters/decoders.

---
 rtl/rtc_set_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_rtc_set_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/rtc_set_ctrl.sv
// Time-set controller for the HH:MM:SS counters: freezes counting, edits a shadow
// copy field by field via mode/up/down buttons with auto-repeat, then loads it back.
module rtc_set_ctrl #(
   parameter int TICKS_REPEAT_DLY  = 500,
   parameter int TICKS_REPEAT_RATE = 100,
   parameter int TICKS_BLINK_HALF  = 250,
   parameter int TIMEOUT_S         = 30
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick_1khz,
   input  logic       tick_1hz,
   input  logic       btn_mode,
   input  logic       btn_up,
   input  logic       btn_dn,
   input  logic [1:0] cur_hr1,
   input  logic [3:0] cur_hr0,
   input  logic [2:0] cur_min1,
   input  logic [3:0] cur_min0,
   input  logic [2:0] cur_sec1,
   input  logic [3:0] cur_sec0,
   output logic       run_en,
   output logic       load,
   output logic [1:0] set_hr1,
   output logic [3:0] set_hr0,
   output logic [2:0] set_min1,
   output logic [3:0] set_min0,
   output logic [2:0] set_sec1,
   output logic [3:0] set_sec0,
   output logic       disp_sel,
   output logic [5:0] blink_mask
);
   // state   | meaning
   // RUN     | counters run, live time displayed
   // SET_HR  | counters frozen, editing shadow hours
   // SET_MIN | counters frozen, editing shadow minutes
   // SET_SEC | counters frozen, editing shadow seconds
   // COMMIT  | one-cycle parallel load of the shadow into the counters
   typedef enum logic [2:0] {RUN, SET_HR, SET_MIN, SET_SEC, COMMIT} state_t;

   localparam int HW = $clog2(TICKS_REPEAT_DLY + 1);
   localparam int BW = $clog2(TICKS_BLINK_HALF + 1);
   localparam int IW = $clog2(TIMEOUT_S + 1);

   state_t        state;
   logic          mode_q, up_q, dn_q;
   logic [HW-1:0] hold_cnt;
   logic [BW-1:0] blink_cnt;
   logic [IW-1:0] idle_cnt;
   logic          blink_ph;

   logic          mode_press, up_press, dn_press, any_press;
   logic          in_set, one_held, rpt_hit, step_up, step_dn, do_step, idle_hit;
   logic [2:0]    f_t, max_t;
   logic [3:0]    f_u, max_u;
   logic [6:0]    step_val;
   logic [5:0]    sel_mask;

   // Field step on a {tens,units} BCD pair with inclusive maximum {mt,mu}.
   function automatic logic [6:0] bcd_step(input logic [2:0] t, input logic [3:0] u,
                                           input logic [2:0] mt, input logic [3:0] mu,
                                           input logic up);
      logic [6:0] r;
      if (up) begin
         if (t > mt || (t == mt && u >= mu)) r = 7'd0;
         else if (u >= 4'd9)                 r = {t + 3'd1, 4'd0};
         else                                r = {t, u + 4'd1};
      end else begin
         if ((t == 3'd0 && u == 4'd0) || t > mt || (t == mt && u > mu)) r = {mt, mu};
         else if (u == 4'd0)                                             r = {t - 3'd1, 4'd9};
         else if (u > 4'd9)                                              r = {t, 4'd9};
         else                                                            r = {t, u - 4'd1};
      end
      return r;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q <= 1'b0;
         up_q   <= 1'b0;
         dn_q   <= 1'b0;
      end else begin
         mode_q <= btn_mode;
         up_q   <= btn_up;
         dn_q   <= btn_dn;
      end
   end

   assign mode_press = btn_mode & ~mode_q;
   assign up_press   = btn_up & ~up_q;
   assign dn_press   = btn_dn & ~dn_q;
   assign any_press  = up_press | dn_press;
   assign in_set     = (state == SET_HR) || (state == SET_MIN) || (state == SET_SEC);
   assign one_held   = btn_up ^ btn_dn;
   assign rpt_hit    = in_set & tick_1khz & one_held & ~any_press &
                       (hold_cnt == HW'(TICKS_REPEAT_DLY - 1));
   // Holding the opposite button vetoes both the immediate step and repeats.
   assign step_up    = in_set & ~btn_dn & (up_press | (rpt_hit & btn_up));
   assign step_dn    = in_set & ~btn_up & (dn_press | (rpt_hit & btn_dn));
   assign do_step    = (step_up | step_dn) & ~mode_press;
   assign idle_hit   = in_set & tick_1hz & ~any_press & (idle_cnt == IW'(TIMEOUT_S - 1));

   always_comb begin
      f_t      = 3'd0;
      f_u      = 4'd0;
      max_t    = 3'd0;
      max_u    = 4'd0;
      sel_mask = 6'b000000;
      case (state)
         SET_HR:  begin f_t = {1'b0, set_hr1}; f_u = set_hr0;  max_t = 3'd2; max_u = 4'd3; sel_mask = 6'b110000; end
         SET_MIN: begin f_t = set_min1;        f_u = set_min0; max_t = 3'd5; max_u = 4'd9; sel_mask = 6'b001100; end
         SET_SEC: begin f_t = set_sec1;        f_u = set_sec0; max_t = 3'd5; max_u = 4'd9; sel_mask = 6'b000011; end
         default: ;
      endcase
      step_val = bcd_step(f_t, f_u, max_t, max_u, step_up);
   end

   // Hold counter reloads to DLY-RATE after each repeat so later repeats land every RATE ticks.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         hold_cnt <= '0;
      else if (!in_set || !one_held || any_press)
         hold_cnt <= '0;
      else if (tick_1khz)
         hold_cnt <= (hold_cnt == HW'(TICKS_REPEAT_DLY - 1)) ?
                     HW'(TICKS_REPEAT_DLY - TICKS_REPEAT_RATE) : hold_cnt + HW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= RUN;
         run_en     <= 1'b1;
         load       <= 1'b0;
         disp_sel   <= 1'b0;
         blink_mask <= 6'b000000;
         set_hr1    <= '0;
         set_hr0    <= '0;
         set_min1   <= '0;
         set_min0   <= '0;
         set_sec1   <= '0;
         set_sec0   <= '0;
         blink_cnt  <= '0;
         blink_ph   <= 1'b0;
         idle_cnt   <= '0;
      end else begin
         load <= 1'b0;
         case (state)
            RUN: begin
               run_en     <= 1'b1;
               disp_sel   <= 1'b0;
               blink_mask <= 6'b000000;
               blink_cnt  <= '0;
               blink_ph   <= 1'b0;
               idle_cnt   <= '0;
               if (mode_press) begin
                  set_hr1  <= cur_hr1;
                  set_hr0  <= cur_hr0;
                  set_min1 <= cur_min1;
                  set_min0 <= cur_min0;
                  set_sec1 <= cur_sec1;
                  set_sec0 <= cur_sec0;
                  state    <= SET_HR;
                  run_en   <= 1'b0;
                  disp_sel <= 1'b1;
               end
            end
            SET_HR, SET_MIN, SET_SEC: begin
               if (mode_press) begin
                  blink_cnt  <= '0;
                  blink_ph   <= 1'b0;
                  blink_mask <= 6'b000000;
                  idle_cnt   <= '0;
                  case (state)
                     SET_HR:  state <= SET_MIN;
                     SET_MIN: state <= SET_SEC;
                     default: begin state <= COMMIT; load <= 1'b1; end
                  endcase
               end else if (do_step) begin
                  case (state)
                     SET_HR:  begin set_hr1  <= step_val[5:4]; set_hr0  <= step_val[3:0]; end
                     SET_MIN: begin set_min1 <= step_val[6:4]; set_min0 <= step_val[3:0]; end
                     default: begin set_sec1 <= step_val[6:4]; set_sec0 <= step_val[3:0]; end
                  endcase
                  blink_cnt  <= '0;
                  blink_ph   <= 1'b0;
                  blink_mask <= 6'b000000;
                  idle_cnt   <= '0;
               end else if (idle_hit) begin
                  state      <= RUN;
                  run_en     <= 1'b1;
                  disp_sel   <= 1'b0;
                  blink_mask <= 6'b000000;
                  blink_cnt  <= '0;
                  blink_ph   <= 1'b0;
                  idle_cnt   <= '0;
               end else begin
                  if (any_press)     idle_cnt <= '0;
                  else if (tick_1hz) idle_cnt <= idle_cnt + IW'(1);
                  if (tick_1khz) begin
                     if (blink_cnt == BW'(TICKS_BLINK_HALF - 1)) begin
                        blink_cnt  <= '0;
                        blink_ph   <= ~blink_ph;
                        blink_mask <= blink_ph ? 6'b000000 : sel_mask;
                     end else begin
                        blink_cnt <= blink_cnt + BW'(1);
                     end
                  end
               end
            end
            COMMIT: begin
               run_en   <= 1'b1;
               disp_sel <= 1'b0;
               state    <= RUN;
            end
            default: begin
               state    <= RUN;
               run_en   <= 1'b1;
               disp_sel <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_rtc_set_ctrl.sv
// Directed bench for rtc_set_ctrl with a small BCD time-counter model standing in
// for the downstream counters.
module tb_rtc_set_ctrl;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tick_1khz = 1'b0, tick_1hz = 1'b0;
   logic       btn_mode = 1'b0, btn_up = 1'b0, btn_dn = 1'b0;
   logic [1:0] c_hr1;
   logic [3:0] c_hr0, c_min0, c_sec0;
   logic [2:0] c_min1, c_sec1;
   logic       run_en, load, disp_sel;
   logic [1:0] set_hr1;
   logic [3:0] set_hr0, set_min0, set_sec0;
   logic [2:0] set_min1, set_sec1;
   logic [5:0] blink_mask;

   logic       pre_en = 1'b0;
   logic [1:0] p_hr1 = '0;
   logic [3:0] p_hr0 = '0, p_min0 = '0, p_sec0 = '0;
   logic [2:0] p_min1 = '0, p_sec1 = '0;
   logic [23:0] live, shadow;
   int total = 0, bad = 0, load_cnt = 0, l0;

   rtc_set_ctrl dut (
      .clk(clk), .rst(rst), .tick_1khz(tick_1khz), .tick_1hz(tick_1hz),
      .btn_mode(btn_mode), .btn_up(btn_up), .btn_dn(btn_dn),
      .cur_hr1(c_hr1), .cur_hr0(c_hr0), .cur_min1(c_min1), .cur_min0(c_min0),
      .cur_sec1(c_sec1), .cur_sec0(c_sec0),
      .run_en(run_en), .load(load),
      .set_hr1(set_hr1), .set_hr0(set_hr0), .set_min1(set_min1), .set_min0(set_min0),
      .set_sec1(set_sec1), .set_sec0(set_sec0),
      .disp_sel(disp_sel), .blink_mask(blink_mask)
   );

   always #10 clk = ~clk;

   assign live   = {2'b00, c_hr1, c_hr0, 1'b0, c_min1, c_min0, 1'b0, c_sec1, c_sec0};
   assign shadow = {2'b00, set_hr1, set_hr0, 1'b0, set_min1, set_min0, 1'b0, set_sec1, set_sec0};

   // Downstream HH:MM:SS counters: preset (bench only), parallel load, 1 Hz count.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         c_hr1 <= '0; c_hr0 <= '0; c_min1 <= '0; c_min0 <= '0; c_sec1 <= '0; c_sec0 <= '0;
      end else if (pre_en) begin
         c_hr1 <= p_hr1; c_hr0 <= p_hr0; c_min1 <= p_min1; c_min0 <= p_min0;
         c_sec1 <= p_sec1; c_sec0 <= p_sec0;
      end else if (load) begin
         c_hr1 <= set_hr1; c_hr0 <= set_hr0; c_min1 <= set_min1; c_min0 <= set_min0;
         c_sec1 <= set_sec1; c_sec0 <= set_sec0;
      end else if (run_en && tick_1hz) begin
         if (c_sec0 != 4'd9) c_sec0 <= c_sec0 + 4'd1;
         else begin
            c_sec0 <= 4'd0;
            if (c_sec1 != 3'd5) c_sec1 <= c_sec1 + 3'd1;
            else begin
               c_sec1 <= 3'd0;
               if (c_min0 != 4'd9) c_min0 <= c_min0 + 4'd1;
               else begin
                  c_min0 <= 4'd0;
                  if (c_min1 != 3'd5) c_min1 <= c_min1 + 3'd1;
                  else begin
                     c_min1 <= 3'd0;
                     if (c_hr1 == 2'd2 && c_hr0 == 4'd3) begin c_hr1 <= 2'd0; c_hr0 <= 4'd0; end
                     else if (c_hr0 == 4'd9) begin c_hr0 <= 4'd0; c_hr1 <= c_hr1 + 2'd1; end
                     else c_hr0 <= c_hr0 + 4'd1;
                  end
               end
            end
         end
      end
   end

   always @(posedge clk) if (load === 1'b1) load_cnt <= load_cnt + 1;

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic khz(input int n);
      repeat (n) begin tick_1khz = 1'b1; cyc(1); tick_1khz = 1'b0; cyc(1); end
   endtask

   task automatic hz(input int n);
      repeat (n) begin tick_1hz = 1'b1; cyc(1); tick_1hz = 1'b0; cyc(1); end
   endtask

   task automatic press(input int b);
      if (b == 0) btn_mode = 1'b1; else if (b == 1) btn_up = 1'b1; else btn_dn = 1'b1;
      cyc(1);
      btn_mode = 1'b0; btn_up = 1'b0; btn_dn = 1'b0;
      cyc(1);
   endtask

   task automatic preset(input int h1, input int h0, input int m1, input int m0,
                         input int s1, input int s0);
      p_hr1 = 2'(h1); p_hr0 = 4'(h0); p_min1 = 3'(m1); p_min0 = 4'(m0);
      p_sec1 = 3'(s1); p_sec0 = 4'(s0);
      pre_en = 1'b1; cyc(1); pre_en = 1'b0; cyc(1);
   endtask

   task automatic test_reset;
      rst = 1'b1; cyc(3);
      total++; if (run_en !== 1'b1 || load !== 1'b0 || disp_sel !== 1'b0 || blink_mask !== 6'b0) begin
         bad++; $display("FAIL reset_outputs got run=%b load=%b disp=%b mask=%b exp 1 0 0 000000", run_en, load, disp_sel, blink_mask); end
      rst = 1'b0; cyc(2);
      total++; if (shadow !== 24'h000000) begin bad++; $display("FAIL reset_shadow got=%h exp=000000", shadow); end
      hz(5);
      total++; if (live !== 24'h000005) begin bad++; $display("FAIL reset_run5 got=%h exp=000005", live); end
   endtask

   task automatic test_edit_commit;
      preset(1, 2, 3, 4, 5, 6);
      l0 = load_cnt;
      press(0);
      total++; if (shadow !== 24'h123456 || run_en !== 1'b0 || disp_sel !== 1'b1) begin
         bad++; $display("FAIL capture got=%h run=%b disp=%b exp=123456 0 1", shadow, run_en, disp_sel); end
      hz(1);
      total++; if (live !== 24'h123456) begin bad++; $display("FAIL frozen got=%h exp=123456", live); end
      press(1); press(1); press(1);
      total++; if (shadow !== 24'h153456) begin bad++; $display("FAIL hr_up3 got=%h exp=153456", shadow); end
      press(0); press(2); press(0);
      total++; if (shadow !== 24'h153356) begin bad++; $display("FAIL min_dn got=%h exp=153356", shadow); end
      btn_mode = 1'b1; cyc(1);
      total++; if (load !== 1'b1 || run_en !== 1'b0 || shadow !== 24'h153356) begin
         bad++; $display("FAIL commit_cycle got load=%b run=%b set=%h exp 1 0 153356", load, run_en, shadow); end
      btn_mode = 1'b0; cyc(1);
      total++; if (live !== 24'h153356 || run_en !== 1'b1 || load !== 1'b0) begin
         bad++; $display("FAIL after_load got live=%h run=%b load=%b exp 153356 1 0", live, run_en, load); end
      hz(1);
      total++; if (live !== 24'h153357) begin bad++; $display("FAIL count_after_load got=%h exp=153357", live); end
      total++; if (load_cnt - l0 !== 1) begin bad++; $display("FAIL load_pulses got=%0d exp=1", load_cnt - l0); end
   endtask

   task automatic test_wrap;
      preset(2, 3, 5, 9, 0, 0);
      press(0);
      press(1);
      total++; if (shadow !== 24'h005900) begin bad++; $display("FAIL hr_wrap_up got=%h exp=005900", shadow); end
      press(2);
      total++; if (shadow !== 24'h235900) begin bad++; $display("FAIL hr_wrap_dn got=%h exp=235900", shadow); end
      press(0); press(1);
      total++; if (shadow !== 24'h230000) begin bad++; $display("FAIL min_wrap_up got=%h exp=230000", shadow); end
      press(0); press(2);
      total++; if (shadow !== 24'h230059) begin bad++; $display("FAIL sec_wrap_dn got=%h exp=230059", shadow); end
      press(0);
      total++; if (live !== 24'h230059 || run_en !== 1'b1) begin
         bad++; $display("FAIL wrap_commit got live=%h run=%b exp 230059 1", live, run_en); end
   endtask

   task automatic test_repeat;
      preset(1, 0, 0, 0, 2, 0);
      press(0); press(0);
      btn_up = 1'b1; cyc(1);
      total++; if (shadow !== 24'h100120) begin bad++; $display("FAIL rpt_immediate got=%h exp=100120", shadow); end
      khz(499);
      total++; if (shadow !== 24'h100120) begin bad++; $display("FAIL rpt_before_dly got=%h exp=100120", shadow); end
      khz(1);
      total++; if (shadow !== 24'h100220) begin bad++; $display("FAIL rpt_at_dly got=%h exp=100220", shadow); end
      khz(300);
      total++; if (shadow !== 24'h100520) begin bad++; $display("FAIL rpt_800 got=%h exp=100520", shadow); end
      btn_up = 1'b0; cyc(2);
      btn_up = 1'b1; btn_dn = 1'b1; cyc(1);
      khz(600);
      total++; if (shadow !== 24'h100520) begin bad++; $display("FAIL both_held got=%h exp=100520", shadow); end
      btn_up = 1'b0; btn_dn = 1'b0; cyc(2);
   endtask

   task automatic test_timeout_blink;
      l0 = load_cnt;
      press(0);
      total++; if (blink_mask !== 6'b000000) begin bad++; $display("FAIL blink_enter got=%b exp=000000", blink_mask); end
      khz(249);
      total++; if (blink_mask !== 6'b000000) begin bad++; $display("FAIL blink_249 got=%b exp=000000", blink_mask); end
      khz(1);
      total++; if (blink_mask !== 6'b000011) begin bad++; $display("FAIL blink_on got=%b exp=000011", blink_mask); end
      khz(250);
      total++; if (blink_mask !== 6'b000000) begin bad++; $display("FAIL blink_off got=%b exp=000000", blink_mask); end
      khz(250);
      total++; if (blink_mask !== 6'b000011) begin bad++; $display("FAIL blink_on2 got=%b exp=000011", blink_mask); end
      hz(29);
      total++; if (run_en !== 1'b0 || disp_sel !== 1'b1) begin
         bad++; $display("FAIL before_timeout got run=%b disp=%b exp 0 1", run_en, disp_sel); end
      hz(1);
      total++; if (run_en !== 1'b1 || disp_sel !== 1'b0 || blink_mask !== 6'b0 || live !== 24'h100020) begin
         bad++; $display("FAIL timeout got run=%b disp=%b mask=%b live=%h exp 1 0 000000 100020", run_en, disp_sel, blink_mask, live); end
      total++; if (load_cnt - l0 !== 0) begin bad++; $display("FAIL timeout_load got=%0d exp=0", load_cnt - l0); end
      hz(1);
      total++; if (live !== 24'h100021) begin bad++; $display("FAIL resume got=%h exp=100021", live); end
   endtask

   task automatic test_reset_mid_edit;
      preset(0, 8, 1, 5, 3, 0);
      press(0); press(0); press(1); press(1);
      total++; if (shadow !== 24'h081730) begin bad++; $display("FAIL pre_reset_edit got=%h exp=081730", shadow); end
      l0 = load_cnt;
      rst = 1'b1; #1;
      total++; if (run_en !== 1'b1 || load !== 1'b0 || disp_sel !== 1'b0 || blink_mask !== 6'b0 || shadow !== 24'h0) begin
         bad++; $display("FAIL async_reset got run=%b load=%b disp=%b mask=%b set=%h exp 1 0 0 000000 000000", run_en, load, disp_sel, blink_mask, shadow); end
      cyc(2); rst = 1'b0; cyc(3);
      press(1);
      total++; if (shadow !== 24'h0 || run_en !== 1'b1 || load_cnt - l0 !== 0) begin
         bad++; $display("FAIL after_reset got set=%h run=%b loads=%0d exp 000000 1 0", shadow, run_en, load_cnt - l0); end
   endtask

   initial begin
      test_reset;
      test_edit_commit;
      test_wrap;
      test_repeat;
      test_timeout_blink;
      test_reset_mid_edit;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
